// File: rtl/bitlogic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bitlogic_pkg                                              |
// | Purpose  : Shared constants for the bitlogic_pipe block: opcode      |
// |            encoding, frame state encoding and out_red bit indices.   |
// | Ports    : none (package)                                            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package bitlogic_pkg;

  // Opcode field width; the encoding below only fits three bits.
  localparam int OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_AND   = 3'd0;
  localparam logic [OPCODE_W-1:0] OP_OR    = 3'd1;
  localparam logic [OPCODE_W-1:0] OP_XOR   = 3'd2;
  localparam logic [OPCODE_W-1:0] OP_XNOR  = 3'd3;
  localparam logic [OPCODE_W-1:0] OP_NAND  = 3'd4;
  localparam logic [OPCODE_W-1:0] OP_NOR   = 3'd5;
  localparam logic [OPCODE_W-1:0] OP_ANDN  = 3'd6;
  localparam logic [OPCODE_W-1:0] OP_PASSA = 3'd7;

  // Frame state: IDLE uses in_a as operand A, ACCUM uses the accumulator.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // Bit positions inside out_red.
  localparam int RED_AND = 0;
  localparam int RED_OR  = 1;
  localparam int RED_XOR = 2;

endpackage
`default_nettype wire

// File: rtl/bitlogic_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bitlogic_if                                               |
// | Purpose  : Bundles the input-beat and result handshakes of           |
// |            bitlogic_pipe.                                            |
// | Ports    : in_valid/in_ready/in_a/in_b/in_op/in_acc/in_last (beat),  |
// |            out_valid/out_ready/out_data/out_red/out_last (result).   |
// |            master = beat producer / result consumer,                 |
// |            slave  = the logic unit.                                  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface bitlogic_if
  import bitlogic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = OPCODE_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [OPW-1:0]   in_op;
  logic             in_acc;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_red;
  logic             out_last;

  modport master (
    output in_valid, in_a, in_b, in_op, in_acc, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_red, out_last
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_acc, in_last, out_ready,
    output in_ready, out_valid, out_data, out_red, out_last
  );

endinterface
`default_nettype wire

// File: rtl/bitlogic_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bitlogic_alu                                              |
// | Purpose  : Combinational bitwise operator, one of eight ops.         |
// | Ports    : a, b (WIDTH) operands; op (OPW) opcode;                   |
// |            result (WIDTH) op(a, b).                                  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module bitlogic_alu
  import bitlogic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = OPCODE_W
) (
  input  wire logic [WIDTH-1:0] a,
  input  wire logic [WIDTH-1:0] b,
  input  wire logic [OPW-1:0]   op,
  output logic      [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_XNOR:  result = ~(a ^ b);
      OP_NAND:  result = ~(a & b);
      OP_NOR:   result = ~(a | b);
      OP_ANDN:  result = a & ~b;
      OP_PASSA: result = a;
      default:  result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bitlogic_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bitlogic_pipe                                             |
// | Purpose  : Registered bitwise logic unit with optional frame         |
// |            accumulation and valid/ready on both sides.               |
// | Ports    : clk   - clock, rising edge                                |
// |            rst_n - synchronous active-low reset                      |
// |            bus   - bitlogic_if.slave (beat in, result out)           |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module bitlogic_pipe
  import bitlogic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = OPCODE_W
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  bitlogic_if.slave   bus
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] alu_res;
  logic [2:0]       red_nxt;
  logic             accept;
  logic             load_out;
  logic             last_nxt;

  // The register can take a new beat whenever it is empty or being drained.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Only a frame beat continues the accumulator; a non-frame beat arriving
  // mid-frame aborts it and operates on its own in_a.
  assign op_a = (state == ST_ACCUM && bus.in_acc) ? acc_q : bus.in_a;

  bitlogic_alu #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu (
    .a      (op_a),
    .b      (bus.in_b),
    .op     (bus.in_op),
    .result (alu_res)
  );

  always_comb begin
    red_nxt          = 3'b000;
    red_nxt[RED_AND] = &alu_res;
    red_nxt[RED_OR]  = |alu_res;
    red_nxt[RED_XOR] = ^alu_res;
  end

  // Next-state / control decode.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc_q;
    load_out  = 1'b0;
    last_nxt  = 1'b0;
    if (accept) begin
      if (!bus.in_acc) begin
        load_out  = 1'b1;
        state_nxt = ST_IDLE;
        acc_nxt   = '0;
      end else if (bus.in_last) begin
        load_out  = 1'b1;
        last_nxt  = 1'b1;
        state_nxt = ST_IDLE;
        acc_nxt   = '0;
      end else begin
        state_nxt = ST_ACCUM;
        acc_nxt   = alu_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc_q <= '0;
    end else begin
      state <= state_nxt;
      acc_q <= acc_nxt;
    end
  end

  // Output register: a drain with no new result only clears valid, so the
  // last payload simply stays put.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_red   <= 3'b000;
      bus.out_last  <= 1'b0;
    end else if (load_out) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= alu_res;
      bus.out_red   <= red_nxt;
      bus.out_last  <= last_nxt;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bitlogic_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_bitlogic_pipe                                          |
// | Purpose  : Directed self-checking bench for bitlogic_pipe (WIDTH=8). |
// | Ports    : none                                                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_bitlogic_pipe;
  import bitlogic_pkg::*;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  bitlogic_if #(.WIDTH(WIDTH), .OPW(OPCODE_W)) bus ();

  bitlogic_pipe #(.WIDTH(WIDTH), .OPW(OPCODE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic acc, input logic last);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_acc   = acc;
    bus.in_last  = last;
  endtask

  task automatic result(input string tag, input logic [7:0] d, input logic [2:0] red,
                        input logic last);
    chk({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, ".data"},  {24'd0, bus.out_data},  {24'd0, d});
    chk({tag, ".red"},   {29'd0, bus.out_red},   {29'd0, red});
    chk({tag, ".last"},  {31'd0, bus.out_last},  {31'd0, last});
  endtask

  logic [7:0] single_exp [8];

  initial begin
    vectors     = 0;
    miscompares = 0;
    single_exp  = '{8'h30, 8'hFC, 8'hCC, 8'h33, 8'hCF, 8'h03, 8'hC0, 8'hF0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = '0;
    bus.in_acc    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst.valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.data",  {24'd0, bus.out_data},  32'd0);
    chk("rst.red",   {29'd0, bus.out_red},   32'd0);
    chk("rst.last",  {31'd0, bus.out_last},  32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Every opcode on F0 / 3C; all results have an even, nonzero, non-full popcount
    for (int op = 0; op < 8; op++) begin
      beat(8'hF0, 8'h3C, op[2:0], 1'b0, 1'b0);
      tick();
      result($sformatf("single%0d", op), single_exp[op], 3'b010, 1'b0);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("drain.valid", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure: hold 30 while a second beat waits
    bus.out_ready = 1'b0;
    beat(8'hF0, 8'h3C, OP_AND, 1'b0, 1'b0);
    tick();
    beat(8'hF0, 8'h3C, OP_OR, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d.in_ready", i), {31'd0, bus.in_ready}, 32'd0);
      result($sformatf("bp%0d", i), 8'h30, 3'b010, 1'b0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.release.in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    result("bp.refill", 8'hFC, 3'b010, 1'b0);
    bus.in_valid = 1'b0;
    tick();

    // XOR frame: 01^02^04^08
    beat(8'h01, 8'h02, OP_XOR, 1'b1, 1'b0);
    tick();
    chk("fx.b0.valid", {31'd0, bus.out_valid}, 32'd0);
    beat(8'h00, 8'h04, OP_XOR, 1'b1, 1'b0);
    tick();
    chk("fx.b1.valid", {31'd0, bus.out_valid}, 32'd0);
    beat(8'h00, 8'h08, OP_XOR, 1'b1, 1'b1);
    tick();
    result("fx.end", 8'h0F, 3'b010, 1'b1);

    // Mixed-op frame: AND(FF,0F) then OR 30
    beat(8'hFF, 8'h0F, OP_AND, 1'b1, 1'b0);
    tick();
    chk("fm.b0.valid", {31'd0, bus.out_valid}, 32'd0);
    beat(8'h00, 8'h30, OP_OR, 1'b1, 1'b1);
    tick();
    result("fm.end", 8'h3F, 3'b010, 1'b1);

    // Abort: frame beat then a non-frame AND(AA,0F)
    beat(8'hFF, 8'hF0, OP_AND, 1'b1, 1'b0);
    tick();
    beat(8'hAA, 8'h0F, OP_AND, 1'b0, 1'b0);
    tick();
    result("abort", 8'h0A, 3'b010, 1'b0);
    // Back in IDLE: a single-beat PASS_A frame must use in_a
    beat(8'h55, 8'h00, OP_PASSA, 1'b1, 1'b1);
    tick();
    result("abort.idle", 8'h55, 3'b010, 1'b1);

    // Reset mid-frame
    beat(8'h12, 8'h21, OP_OR, 1'b1, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    tick();
    chk("mrst.valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mrst.data",  {24'd0, bus.out_data},  32'd0);
    chk("mrst.red",   {29'd0, bus.out_red},   32'd0);
    chk("mrst.last",  {31'd0, bus.out_last},  32'd0);
    rst_n = 1'b1;
    tick();
    beat(8'h40, 8'h04, OP_OR, 1'b1, 1'b1);
    tick();
    result("mrst.fresh", 8'h44, 3'b010, 1'b1);

    // Reduction corners
    beat(8'hF0, 8'h0F, OP_OR, 1'b0, 1'b0);
    tick();
    result("red.ff", 8'hFF, 3'b011, 1'b0);
    beat(8'h05, 8'h02, OP_XOR, 1'b0, 1'b0);
    tick();
    result("red.07", 8'h07, 3'b110, 1'b0);
    beat(8'hFF, 8'h00, OP_NOR, 1'b0, 1'b0);
    tick();
    result("red.00", 8'h00, 3'b000, 1'b0);
    bus.in_valid = 1'b0;
    tick();

    // Throughput: 16 back-to-back beats, one result per cycle
    for (int i = 0; i < 16; i++) begin
      beat(i[7:0], 8'hA5, OP_XOR, 1'b0, 1'b0);
      tick();
      chk($sformatf("tp%0d.valid", i), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("tp%0d.data", i),  {24'd0, bus.out_data},  {24'd0, i[7:0] ^ 8'hA5});
      chk($sformatf("tp%0d.in_ready", i), {31'd0, bus.in_ready}, 32'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("tp.drain.valid", {31'd0, bus.out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
